// File: rtl/mult_defs.sv
// Shared definitions for the iterative 32x32 shift-and-add multiplier.
// Holds the default operand width, counter width and FSM state encodings.
package mult_defs;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W_DEF = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_mult_32_if.sv
// Start/busy/done handshake and HI/LO result bus of the multiplier.
// master = controller side, slave = multiplier side.
interface seq_mult_32_if #(
    parameter int WIDTH = 32
);

    logic             start;
    logic             signed_op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             hi_load;
    logic             lo_load;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, signed_op, a, b,
        input  busy, done, hi_load, lo_load, hi, lo
    );

    modport slave (
        input  start, signed_op, a, b,
        output busy, done, hi_load, lo_load, hi, lo
    );

endinterface

// File: rtl/mult_step.sv
// One shift-and-add iteration: conditionally add the multiplicand into the
// upper half, then shift the whole {carry, upper, lower} right by one.
module mult_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_upper,
    input  logic [WIDTH-1:0] i_lower,
    input  logic [WIDTH-1:0] i_m,
    output logic [WIDTH-1:0] o_upper,
    output logic [WIDTH-1:0] o_lower
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_addend;

    // The carry out of the add becomes the new MSB of the upper half.
    assign w_addend = i_lower[0] ? {1'b0, i_m} : '0;
    assign w_sum    = {1'b0, i_upper} + w_addend;
    assign o_upper  = w_sum[WIDTH:1];
    assign o_lower  = {w_sum[0], i_lower[WIDTH-1:1]};

endmodule

// File: rtl/seq_mult_32.sv
// Iterative 32x32 -> 64 multiplier, one product bit per clock, HI/LO outputs.
// Optional signed mode is built only when MULT_SIGNED_EN is defined.
module seq_mult_32
    import mult_defs::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_mult_32_if.slave  bus
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_m;
    logic [WIDTH-1:0]   r_upper;
    logic [WIDTH-1:0]   r_lower;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;
    logic               r_done;

    logic [WIDTH-1:0]   w_nx_upper;
    logic [WIDTH-1:0]   w_nx_lower;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_res;
    logic               w_accept;

    mult_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_upper (r_upper),
        .i_lower (r_lower),
        .i_m     (r_m),
        .o_upper (w_nx_upper),
        .o_lower (w_nx_lower)
    );

    // Product as it will stand after the iteration in progress.
    assign w_prod = {w_nx_upper, w_nx_lower};

`ifdef MULT_SIGNED_EN
    logic w_neg_a;
    logic w_neg_b;
    logic r_neg;

    // Operate on magnitudes; the most negative value maps to itself,
    // which read as unsigned is exactly its magnitude.
    assign w_neg_a = bus.signed_op & bus.a[WIDTH-1];
    assign w_neg_b = bus.signed_op & bus.b[WIDTH-1];
    assign w_a_mag = w_neg_a ? (~bus.a + WIDTH'(1)) : bus.a;
    assign w_b_mag = w_neg_b ? (~bus.b + WIDTH'(1)) : bus.b;
    assign w_res   = r_neg ? (~w_prod + (2*WIDTH)'(1)) : w_prod;
`else
    logic w_unused_sgn;

    assign w_unused_sgn = bus.signed_op;
    assign w_a_mag      = bus.a;
    assign w_b_mag      = bus.b;
    assign w_res        = w_prod;
`endif

    assign w_accept = bus.start &
                      ((r_state == ST_IDLE) | (r_state == ST_DONE));

    // Control FSM with operand capture, iteration and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_m     <= '0;
            r_upper <= '0;
            r_lower <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef MULT_SIGNED_EN
            r_neg   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_accept) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                        r_m     <= w_a_mag;
                        r_upper <= '0;
                        r_lower <= w_b_mag;
`ifdef MULT_SIGNED_EN
                        r_neg   <= w_neg_a ^ w_neg_b;
`endif
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    r_upper <= w_nx_upper;
                    r_lower <= w_nx_lower;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_hi    <= w_res[2*WIDTH-1:WIDTH];
                        r_lo    <= w_res[WIDTH-1:0];
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.hi_load = r_done;
    assign bus.lo_load = r_done;
    assign bus.hi      = r_hi;
    assign bus.lo      = r_lo;

endmodule

// File: tb/tb_seq_mult_32.sv
// Self-checking bench for seq_mult_32: vector table, random ops against
// a plain-arithmetic model, and hand sequences for the handshake corners.
module tb_seq_mult_32;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;
    logic [63:0] prev;

    seq_mult_32_if #(.WIDTH(32)) bus ();

    seq_mult_32 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        bit          s;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    function automatic logic [63:0] model(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input bit s);
        logic [63:0] ua;
        logic [63:0] ub;
`ifdef MULT_SIGNED_EN
        longint sa;
        longint sb;
        if (s) begin
            sa = $signed(a);
            sb = $signed(b);
            return 64'(sa * sb);
        end
`else
        bit unused_s;
        unused_s = s;
`endif
        ua = {32'b0, a};
        ub = {32'b0, b};
        return ua * ub;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Follows one op from its accept edge to done. Optionally pulses start
    // mid-run (inj) or drives a chained start in the done cycle.
    task automatic monitor(input logic [31:0] ea, input logic [31:0] eb,
                           input bit es, input string nm,
                           input int inj,
                           input logic [31:0] ia, input logic [31:0] ib,
                           input bit chain,
                           input logic [31:0] ca, input logic [31:0] cb,
                           input bit cs);
        int dcyc;
        int bad_busy;
        int bad_load;
        int bad_hold;
        logic [63:0] exp;
        exp = model(ea, eb, es);
        dcyc = 0;
        bad_busy = 0;
        bad_load = 0;
        bad_hold = 0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (bus.done === 1'b1) begin
                dcyc = k;
                if (bus.hi_load !== 1'b1 || bus.lo_load !== 1'b1)
                    bad_load++;
                break;
            end
            if (bus.hi_load !== 1'b0 || bus.lo_load !== 1'b0)
                bad_load++;
            if (bus.busy !== 1'b1)
                bad_busy++;
            if ({bus.hi, bus.lo} !== prev)
                bad_hold++;
            if (k == inj) begin
                bus.start = 1'b1;
                bus.a = ia;
                bus.b = ib;
            end else if (inj != 0 && k == inj + 1) begin
                bus.start = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        chk({nm, "_latency"}, 64'(dcyc), 64'd33);
        chk({nm, "_busy_run"}, 64'(bad_busy), 64'd0);
        chk({nm, "_loads"}, 64'(bad_load), 64'd0);
        chk({nm, "_hold"}, 64'(bad_hold), 64'd0);
        if (dcyc != 0) begin
            chk({nm, "_busy_done"}, 64'(bus.busy), 64'd0);
            chk({nm, "_product"}, {bus.hi, bus.lo}, exp);
        end
        prev = exp;
        if (chain) begin
            bus.start = 1'b1;
            bus.a = ca;
            bus.b = cb;
            bus.signed_op = cs;
        end
    endtask

    task automatic launch(input logic [31:0] a, input logic [31:0] b,
                          input bit s, input string nm);
        bus.a = a;
        bus.b = b;
        bus.signed_op = s;
        bus.start = 1'b1;
        monitor(a, b, s, nm, 0, '0, '0, 1'b0, '0, '0, 1'b0);
    endtask

    vec_t vt[$];
    int   n_done;

    initial begin
        n_chk = 0;
        n_err = 0;
        prev = '0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.signed_op = 1'b0;
        bus.a = '0;
        bus.b = '0;

        vt.push_back('{32'd3, 32'd5, 1'b0, 32'd0, 32'd15});
        vt.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0,
                       32'hFFFFFFFE, 32'h00000001});
        vt.push_back('{32'd0, 32'hFFFFFFFF, 1'b0, 32'd0, 32'd0});
        vt.push_back('{32'd1, 32'hFFFFFFFF, 1'b0, 32'd0, 32'hFFFFFFFF});
        vt.push_back('{32'd10000, 32'd10000, 1'b0, 32'd0, 32'h05F5E100});
        vt.push_back('{32'h80000000, 32'h80000000, 1'b1,
                       32'h40000000, 32'h00000000});
`ifdef MULT_SIGNED_EN
        vt.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'd0, 32'd1});
        vt.push_back('{32'hFFFFFFFD, 32'd7, 1'b1,
                       32'hFFFFFFFF, 32'hFFFFFFEB});
        vt.push_back('{32'h80000000, 32'd1, 1'b1,
                       32'hFFFFFFFF, 32'h80000000});
`else
        vt.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1,
                       32'hFFFFFFFE, 32'd1});
        vt.push_back('{32'hFFFFFFFD, 32'd7, 1'b1, 32'd6, 32'hFFFFFFEB});
        vt.push_back('{32'h80000000, 32'd1, 1'b1, 32'd0, 32'h80000000});
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_done", 64'(bus.done), 64'd0);
        chk("reset_loads", 64'({bus.hi_load, bus.lo_load}), 64'd0);
        chk("reset_hilo", {bus.hi, bus.lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < vt.size(); i++) begin
            launch(vt[i].a, vt[i].b, vt[i].s, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d_table", i), {bus.hi, bus.lo},
                {vt[i].hi, vt[i].lo});
        end

        for (int i = 0; i < 16; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom;
            rb = $urandom;
            if (i == 3) ra = 32'h80000000;
            if (i == 5) rb = 32'hFFFFFFFF;
            launch(ra, rb, 1'($urandom_range(0, 1)),
                   $sformatf("rnd%0d", i));
        end

        bus.a = 32'd6;
        bus.b = 32'd7;
        bus.signed_op = 1'b0;
        bus.start = 1'b1;
        monitor(32'd6, 32'd7, 1'b0, "ignore_start", 10, 32'd9, 32'd9,
                1'b0, '0, '0, 1'b0);
        chk("ignore_start_lo", 64'(bus.lo), 64'd42);
        repeat (3) @(posedge clk);
        #1;
        chk("ignore_idle", 64'({bus.busy, bus.done}), 64'd0);

        bus.a = 32'd1234;
        bus.b = 32'd5678;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(bus.busy), 64'd0);
        chk("midrst_done", 64'(bus.done), 64'd0);
        chk("midrst_hilo", {bus.hi, bus.lo}, 64'd0);
        prev = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) n_done++;
        end
        chk("midrst_no_done", 64'(n_done), 64'd0);
        launch(32'd100, 32'd100, 1'b0, "after_rst");
        chk("after_rst_lo", 64'(bus.lo), 64'd10000);

        bus.a = 32'd11;
        bus.b = 32'd13;
        bus.signed_op = 1'b0;
        bus.start = 1'b1;
        monitor(32'd11, 32'd13, 1'b0, "b2b_first", 0, '0, '0,
                1'b1, 32'hDEADBEEF, 32'h12345678, 1'b0);
        monitor(32'hDEADBEEF, 32'h12345678, 1'b0, "b2b_second", 0, '0,
                '0, 1'b0, '0, '0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
